// File: rtl/shared_bus_arbiter_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package shared_bus_arbiter_pkg;

    // Payload width of this package variant; the arbiter defaults to it.
    localparam int X             = 1;
    localparam int DEFAULT_WIDTH = X;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Index of the set bit of a one-hot vector (up to 16 requesters).
    // OR-ing indices is exact because at most one bit is set.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/shared_bus_arbiter_rr_pick.sv
// Round-robin pick: first requester at or after ptr, wrapping, as one-hot.
// Latency: purely combinational.
// Backpressure: none; found is simply the OR of all requests.
module shared_bus_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] onehot,
    output logic             found
);

    localparam int DW = 2 * N_REQ;

    logic [DW-1:0] dbl;
    logic [DW-1:0] keep;
    logic [DW-1:0] masked;
    logic [DW-1:0] lowest;

    // Duplicate the request vector, clear bits below ptr, isolate the lowest
    // survivor; a hit in the upper copy is the wrapped-around winner.
    always_comb begin
        dbl    = {req, req};
        keep   = ~((DW'(1) << ptr) - DW'(1));
        masked = dbl & keep;
        lowest = masked & (~masked + DW'(1));
        onehot = lowest[N_REQ-1:0] | lowest[DW-1:N_REQ];
        found  = |req;
    end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter with burst lock sharing one valid/ready payload bus.
// Latency: 1 cycle to grant from IDLE; beats then pass combinationally.
// Backpressure: downstream ready goes only to the owner; others see ready=0.
module shared_bus_arbiter
    import shared_bus_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int MAX_BT = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req_valid,
    input  logic [N_REQ-1:0]       i_req_last,
    input  logic [N_REQ*WIDTH-1:0] i_req_data,
    output logic [N_REQ-1:0]       o_req_ready,
    output logic                   o_valid,
    output logic                   o_last,
    output logic [WIDTH-1:0]       o_data,
    input  logic                   i_ready,
    output logic [N_REQ-1:0]       o_grant,
    output logic                   o_busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BT) + 1;

    state_t           state;
    state_t           state_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_nxt;
    logic [PW-1:0]    ptr_after;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [N_REQ-1:0] pick_oh;
    logic             pick_found;
    logic [WIDTH-1:0] data_mux;
    logic [3:0]       owner_idx;
    logic             xfer;

    shared_bus_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req    (i_req_valid),
        .ptr    (ptr),
        .onehot (pick_oh),
        .found  (pick_found)
    );

    // Owner-steered datapath: grant is zero in IDLE, so nothing leaks out;
    // outputs are forced quiet while reset is asserted.
    always_comb begin
        data_mux = '0;
        for (int k = 0; k < N_REQ; k++) begin
            data_mux = data_mux | (i_req_data[k*WIDTH +: WIDTH] & {WIDTH{o_grant[k]}});
        end
        o_valid     = i_rst & (|(i_req_valid & o_grant));
        o_last      = o_valid & (|(i_req_last & o_grant));
        o_data      = o_valid ? data_mux : '0;
        o_req_ready = i_rst ? (o_grant & {N_REQ{i_ready}}) : '0;
        xfer        = o_valid & i_ready;
    end

    assign o_busy = (state == BUSY);

    // Pointer value after releasing the current owner: one past it, wrapping.
    always_comb begin
        owner_idx = onehot_to_idx(16'(o_grant));
        ptr_after = (owner_idx == 4'(N_REQ - 1)) ? '0 : PW'(owner_idx + 4'd1);
    end

    // Next-state: grant from IDLE, hold the lock in BUSY until a last beat
    // or the watchdog beat transfers.
    always_comb begin
        state_nxt = state;
        grant_nxt = o_grant;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_nxt = pick_oh;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    if (o_last || (cnt == CW'(MAX_BT - 1))) begin
                        grant_nxt = '0;
                        state_nxt = IDLE;
                        ptr_nxt   = ptr_after;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; a burst in flight
    // is simply dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state   <= IDLE;
            o_grant <= '0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            o_grant <= grant_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter, run on a WIDTH=1 and a WIDTH=2 copy.
// Latency: n/a.
// Backpressure: n/a.
module tb_shared_bus_arbiter;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] d;
        logic       l;
    } beat_t;

    typedef struct packed {
        logic [1:0] d;
        logic       l;
    } lb_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready;
    logic [3:0] req_valid;
    logic [3:0] req_last;
    logic [3:0] data_w1;
    logic [7:0] data_w2;

    logic [3:0] rdy_w1, rdy_w2, g1, g2;
    logic       ov1, ov2, ol1, ol2, b1, b2;
    logic [0:0] od1;
    logic [1:0] od2;

    logic       rst_nxt;
    logic       rdy_nxt;
    logic       force_all;
    logic [3:0] hold;

    lb_t   lq[4][$];
    beat_t q1[$];
    beat_t q2[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shared_bus_arbiter #(.N_REQ(4), .WIDTH(1), .MAX_BT(8)) u_w1 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_last(req_last),
        .i_req_data(data_w1), .o_req_ready(rdy_w1), .o_valid(ov1), .o_last(ol1),
        .o_data(od1), .i_ready(ready), .o_grant(g1), .o_busy(b1)
    );

    shared_bus_arbiter #(.N_REQ(4), .WIDTH(2), .MAX_BT(8)) u_w2 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_last(req_last),
        .i_req_data(data_w2), .o_req_ready(rdy_w2), .o_valid(ov2), .o_last(ol2),
        .o_data(od2), .i_ready(ready), .o_grant(g2), .o_busy(b2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic [3:0] g_exp, input logic busy_exp);
        chk({tag, "_grant_w1"}, 32'(g1), 32'(g_exp));
        chk({tag, "_grant_w2"}, 32'(g2), 32'(g_exp));
        chk({tag, "_busy_w1"}, 32'(b1), 32'(busy_exp));
        chk({tag, "_busy_w2"}, 32'(b2), 32'(busy_exp));
    endtask

    task automatic load(input int k, input logic [1:0] d, input logic l);
        lq[k].push_back({d, l});
    endtask

    task automatic expect_beat(input logic [3:0] g, input logic [1:0] d, input logic l);
        q1.push_back({g, d, l});
        q2.push_back({g, d, l});
    endtask

    task automatic clear_lanes();
        for (int k = 0; k < 4; k++) lq[k].delete();
        hold = '0;
    endtask

    task automatic drive();
        rst       = rst_nxt;
        ready     = rdy_nxt;
        req_valid = '0;
        req_last  = '0;
        data_w1   = '0;
        data_w2   = '0;
        for (int k = 0; k < 4; k++) begin
            if (lq[k].size() > 0 && !hold[k]) begin
                req_valid[k]       = 1'b1;
                req_last[k]        = lq[k][0].l;
                data_w1[k]         = lq[k][0].d[0];
                data_w2[2*k +: 2]  = lq[k][0].d;
            end
        end
        if (force_all) req_valid = '1;
    endtask

    // Per-cycle observation: grant sanity, quiet idle outputs, scoreboard pops.
    task automatic monitor();
        beat_t e;
        if (rst) begin
            chk("onehot_w1", 32'($onehot0(g1)), 32'(1));
            chk("onehot_w2", 32'($onehot0(g2)), 32'(1));
        end
        if (!ov1) chk("idle_zero_w1", 32'({ol1, od1}), 32'(0));
        if (!ov2) chk("idle_zero_w2", 32'({ol2, od2}), 32'(0));
        if (ov1 && ready) begin
            chk("sb_avail_w1", 32'(q1.size() > 0), 32'(1));
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("xfer_grant_w1", 32'(g1), 32'(e.g));
                chk("xfer_data_w1", 32'(od1), 32'(e.d[0]));
                chk("xfer_last_w1", 32'(ol1), 32'(e.l));
            end
        end
        if (ov2 && ready) begin
            chk("sb_avail_w2", 32'(q2.size() > 0), 32'(1));
            if (q2.size() > 0) begin
                e = q2.pop_front();
                chk("xfer_grant_w2", 32'(g2), 32'(e.g));
                chk("xfer_data_w2", 32'(od2), 32'(e.d));
                chk("xfer_last_w2", 32'(ol2), 32'(e.l));
            end
        end
    endtask

    // One clock: observe mid-cycle, retire accepted beats, drive next inputs.
    task automatic tick();
        logic [3:0] acc;
        #3;
        monitor();
        acc = req_valid & rdy_w1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (acc[k] && lq[k].size() > 0) void'(lq[k].pop_front());
        end
        drive();
        #1;
    endtask

    task automatic drained(input string tag);
        chk({tag, "_drained_w1"}, 32'(q1.size()), 32'(0));
        chk({tag, "_drained_w2"}, 32'(q2.size()), 32'(0));
    endtask

    task automatic reset_pulse();
        rst_nxt = 1'b0;
        clear_lanes();
        tick();
        rst_nxt = 1'b1;
        tick();
        ctl("rst_pulse", 4'b0000, 1'b0);
    endtask

    initial begin
        // 1: reset held 3 cycles with every requester valid
        rst_nxt = 1'b0; rdy_nxt = 1'b1; force_all = 1'b1; hold = '0;
        drive();
        for (int i = 0; i < 3; i++) begin
            tick();
            ctl("reset", 4'b0000, 1'b0);
            chk("reset_valid_w1", 32'(ov1), 32'(0));
            chk("reset_valid_w2", 32'(ov2), 32'(0));
            chk("reset_ready_w1", 32'(rdy_w1), 32'(0));
            chk("reset_ready_w2", 32'(rdy_w2), 32'(0));
        end
        force_all = 1'b0; rst_nxt = 1'b1;
        tick();
        ctl("post_reset", 4'b0000, 1'b0);

        // 2: single beat from requester 1, then pointer lands on 2
        load(1, 2'd1, 1'b1);
        expect_beat(4'b0010, 2'd1, 1'b1);
        drive();
        tick();
        ctl("single", 4'b0010, 1'b1);
        chk("single_valid_w1", 32'(ov1), 32'(1));
        chk("single_data_w1", 32'(od1), 32'(1));
        chk("single_data_w2", 32'(od2), 32'(1));
        chk("single_ready_w1", 32'(rdy_w1), 32'(4'b0010));
        tick();
        ctl("single_rel", 4'b0000, 1'b0);
        load(0, 2'd2, 1'b1);
        load(3, 2'd3, 1'b1);
        expect_beat(4'b1000, 2'd3, 1'b1);
        expect_beat(4'b0001, 2'd2, 1'b1);
        drive();
        tick(); ctl("ptr2_a", 4'b1000, 1'b1);
        tick(); ctl("ptr2_gap", 4'b0000, 1'b0);
        tick(); ctl("ptr2_b", 4'b0001, 1'b1);
        tick();
        drained("ptr2");
        reset_pulse();

        // 3: round robin over continuously requesting lanes
        load(0, 2'd0, 1'b1); load(0, 2'd3, 1'b1);
        load(1, 2'd1, 1'b1); load(2, 2'd2, 1'b1); load(3, 2'd3, 1'b1);
        expect_beat(4'b0001, 2'd0, 1'b1);
        expect_beat(4'b0010, 2'd1, 1'b1);
        expect_beat(4'b0100, 2'd2, 1'b1);
        expect_beat(4'b1000, 2'd3, 1'b1);
        expect_beat(4'b0001, 2'd3, 1'b1);
        drive();
        for (int i = 0; i < 5; i++) begin
            logic [3:0] order;
            order = 4'b0001 << (i % 4);
            tick(); ctl("rr_grant", order, 1'b1);
            tick(); ctl("rr_gap", 4'b0000, 1'b0);
        end
        drained("rr");

        // 4: requester 2 locks the bus through valid gaps and a ready stall
        load(2, 2'd1, 1'b0); load(2, 2'd2, 1'b0); load(2, 2'd3, 1'b1);
        load(0, 2'd2, 1'b1);
        expect_beat(4'b0100, 2'd1, 1'b0);
        expect_beat(4'b0100, 2'd2, 1'b0);
        expect_beat(4'b0100, 2'd3, 1'b1);
        expect_beat(4'b0001, 2'd2, 1'b1);
        drive();
        tick(); ctl("lock_b1", 4'b0100, 1'b1);
        hold[2] = 1'b1;
        tick(); ctl("lock_gap1", 4'b0100, 1'b1);
        chk("lock_gap_valid_w1", 32'(ov1), 32'(0));
        chk("lock_gap_ready_w1", 32'(rdy_w1), 32'(4'b0100));
        tick(); ctl("lock_gap2", 4'b0100, 1'b1);
        hold[2] = 1'b0; rdy_nxt = 1'b0;
        tick(); ctl("lock_stall", 4'b0100, 1'b1);
        chk("lock_stall_valid_w2", 32'(ov2), 32'(1));
        chk("lock_stall_ready_w2", 32'(rdy_w2), 32'(0));
        rdy_nxt = 1'b1;
        tick(); tick();
        tick(); ctl("lock_rel", 4'b0000, 1'b0);
        tick(); ctl("lock_next", 4'b0001, 1'b1);
        tick();
        drained("lock");

        // 5: watchdog release after 8 beats without last
        for (int i = 1; i <= 10; i++) load(3, 2'(i), 1'b0);
        load(0, 2'd1, 1'b1);
        for (int i = 1; i <= 8; i++) expect_beat(4'b1000, 2'(i), 1'b0);
        expect_beat(4'b0001, 2'd1, 1'b1);
        expect_beat(4'b1000, 2'd1, 1'b0);
        expect_beat(4'b1000, 2'd2, 1'b0);
        drive();
        tick(); ctl("wd_first", 4'b1000, 1'b1);
        repeat (7) tick();
        ctl("wd_beat8", 4'b1000, 1'b1);
        tick(); ctl("wd_rel", 4'b0000, 1'b0);
        tick(); ctl("wd_other", 4'b0001, 1'b1);
        tick(); ctl("wd_gap", 4'b0000, 1'b0);
        tick(); ctl("wd_resume", 4'b1000, 1'b1);
        tick(); tick();
        ctl("wd_still_locked", 4'b1000, 1'b1);
        chk("wd_locked_valid_w1", 32'(ov1), 32'(0));
        drained("wd");
        reset_pulse();

        // 6: reset in the middle of a 4-beat burst
        load(1, 2'd1, 1'b0); load(1, 2'd2, 1'b0); load(1, 2'd3, 1'b0); load(1, 2'd0, 1'b1);
        expect_beat(4'b0010, 2'd1, 1'b0);
        drive();
        tick(); ctl("midrst_b1", 4'b0010, 1'b1);
        rst_nxt = 1'b0;
        tick();
        chk("midrst_valid_w1", 32'(ov1), 32'(0));
        chk("midrst_valid_w2", 32'(ov2), 32'(0));
        chk("midrst_ready_w1", 32'(rdy_w1), 32'(0));
        clear_lanes();
        rst_nxt = 1'b1;
        tick(); ctl("midrst_after", 4'b0000, 1'b0);
        load(0, 2'd2, 1'b1);
        load(1, 2'd3, 1'b1);
        expect_beat(4'b0001, 2'd2, 1'b1);
        expect_beat(4'b0010, 2'd3, 1'b1);
        drive();
        tick(); ctl("midrst_first", 4'b0001, 1'b1);
        tick();
        tick(); ctl("midrst_second", 4'b0010, 1'b1);
        tick();
        drained("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
